// File: rtl/decode_driver_pkg.sv
// Shared definitions for the decode_driver block: FSM state encodings and
// the width of one buffered request entry ({addr, hold}).
package decode_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    // One FIFO entry carries the 2-bit decoder address plus the hold field.
    function automatic int entry_width(input int hold_w);
        return 2 + hold_w;
    endfunction

endpackage

// File: rtl/decode_req_fifo.sv
// Request FIFO for decode_driver. Show-ahead: dout always presents the head
// entry so the consumer can load it on the same edge it pops.
module decode_req_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pushes into a full FIFO and pops from an empty one are ignored.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Storage write; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/decode_driver.sv
// Sequencing front end for a 2-to-4 decoder. Buffers {addr, hold} requests
// and drives address0/address1/enable from registers so exactly one decoder
// output is high for hold+1 cycles, pulsing done on the last one.
// Optional macro DECODE_DRIVER_SETUP_EN inserts a one-cycle SETUP state
// (address stable, enable low) before every ACTIVE phase.
module decode_driver
    import decode_driver_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_addr,
    input  logic [HOLD_W-1:0] req_hold,
    output logic              address0,
    output logic              address1,
    output logic              enable,
    output logic              done,
    output logic              busy
);

    localparam int ENTRY_W = entry_width(HOLD_W);
    localparam int CNT_W   = $clog2(DEPTH) + 1;

`ifdef DECODE_DRIVER_SETUP_EN
    localparam state_t ST_LAUNCH = ST_SETUP;
`else
    localparam state_t ST_LAUNCH = ST_ACTIVE;
`endif

    state_t             state;
    state_t             state_next;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [1:0]         addr_reg;
    logic               enable_reg;

    logic               fifo_push;
    logic               fifo_pop;
    logic [ENTRY_W-1:0] fifo_din;
    logic [ENTRY_W-1:0] fifo_dout;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;

    // Ready looks only at the registered count, never at a same-cycle pop.
    assign req_ready = !fifo_full;
    assign fifo_push = req_valid && req_ready;
    assign fifo_din  = {req_addr, req_hold};

    decode_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .din     (fifo_din),
        .dout    (fifo_dout),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and pop decision: pop from IDLE, or on the last ACTIVE cycle.
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = ST_LAUNCH;
                end
            end
`ifdef DECODE_DRIVER_SETUP_EN
            ST_SETUP: begin
                state_next = ST_ACTIVE;
            end
`endif
            ST_ACTIVE: begin
                if (hold_cnt == '0) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        state_next = ST_LAUNCH;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Status outputs decoded from registered state only.
    always_comb begin
        done = (state == ST_ACTIVE) && (hold_cnt == '0);
        busy = (state != ST_IDLE) || (fifo_count != '0);
    end

    // Datapath registers: address changes only on a pop, enable follows the
    // upcoming state so it is a clean flop output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_reg   <= 2'b00;
            hold_cnt   <= '0;
            enable_reg <= 1'b0;
        end else begin
            if (fifo_pop) begin
                addr_reg <= fifo_dout[ENTRY_W-1 -: 2];
                hold_cnt <= fifo_dout[HOLD_W-1:0];
            end else if ((state == ST_ACTIVE) && (hold_cnt != '0)) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end
            enable_reg <= (state_next == ST_ACTIVE);
        end
    end

    assign address0 = addr_reg[0];
    assign address1 = addr_reg[1];
    assign enable   = enable_reg;

endmodule

// File: tb/tb_decode_driver.sv
// Self-checking bench for decode_driver. The reference model schedules each
// accepted request in closed form: pop edge = max(accept+1, previous end),
// then derives every per-cycle output from that schedule.
module tb_decode_driver;

    localparam int DEPTH  = 2;
    localparam int HOLD_W = 4;
`ifdef DECODE_DRIVER_SETUP_EN
    localparam int S = 1;
`else
    localparam int S = 0;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [1:0]        req_addr = 2'b00;
    logic [HOLD_W-1:0] req_hold = '0;
    logic              address0;
    logic              address1;
    logic              enable;
    logic              done;
    logic              busy;

    decode_driver #(.DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_hold  (req_hold),
        .address0  (address0),
        .address1  (address1),
        .enable    (enable),
        .done      (done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n = 0;

    // Schedule of accepted requests since the last reset (edge numbers).
    int q_acc[$];
    int q_pop[$];
    int q_end[$];
    int q_hold[$];
    int q_addr[$];

    task automatic chk(input string tag, input logic obs, input logic expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, expv, n);
        end
    endtask

    function automatic int fifo_level(input int c);
        int lvl = 0;
        foreach (q_acc[k]) begin
            if (q_acc[k] <= c) lvl++;
            if (q_pop[k] <= c) lvl--;
        end
        return lvl;
    endfunction

    function automatic logic exp_ready(input int c);
        return fifo_level(c) != DEPTH;
    endfunction

    function automatic logic exp_enable(input int c);
        foreach (q_pop[k])
            if (q_pop[k] + S <= c && c <= q_pop[k] + S + q_hold[k]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_done(input int c);
        foreach (q_pop[k])
            if (c == q_pop[k] + S + q_hold[k]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_busy(input int c);
        foreach (q_acc[k])
            if (q_acc[k] <= c && c < q_end[k]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [1:0] exp_addr(input int c);
        logic [1:0] a = 2'b00;
        foreach (q_pop[k])
            if (q_pop[k] <= c) a = 2'(q_addr[k]);
        return a;
    endfunction

    task automatic model_accept(input int edge_no, input int addr, input int hold);
        int p;
        int sz;
        sz = q_acc.size();
        p = edge_no + 1;
        if (sz > 0 && q_end[sz-1] > p) p = q_end[sz-1];
        q_acc.push_back(edge_no);
        q_pop.push_back(p);
        q_end.push_back(p + S + hold + 1);
        q_hold.push_back(hold);
        q_addr.push_back(addr);
    endtask

    task automatic model_reset();
        q_acc.delete();
        q_pop.delete();
        q_end.delete();
        q_hold.delete();
        q_addr.delete();
        n = 0;
    endtask

    task automatic check_all(input string tag);
        logic [1:0] a;
        a = exp_addr(n);
        chk({tag, ".ready"},    req_ready, exp_ready(n));
        chk({tag, ".enable"},   enable,    exp_enable(n));
        chk({tag, ".done"},     done,      exp_done(n));
        chk({tag, ".busy"},     busy,      exp_busy(n));
        chk({tag, ".address0"}, address0,  a[0]);
        chk({tag, ".address1"}, address1,  a[1]);
    endtask

    // One clock: the model takes the request if it expected ready, then all
    // outputs are compared 1 time unit after the edge.
    task automatic tick(input string tag, output bit accepted);
        bit rdy;
        rdy = exp_ready(n);
        @(posedge clk);
        n++;
        accepted = req_valid && rdy;
        if (accepted) model_accept(n, int'(req_addr), int'(req_hold));
        #1;
        check_all(tag);
    endtask

    task automatic idle(input int cycles);
        bit acc;
        req_valid = 1'b0;
        for (int i = 0; i < cycles; i++) tick("idle", acc);
    endtask

    // Present one request and hold it stable until accepted (bounded).
    task automatic send(input logic [1:0] addr, input logic [HOLD_W-1:0] hold);
        bit acc;
        bit got;
        got = 1'b0;
        req_valid = 1'b1;
        req_addr  = addr;
        req_hold  = hold;
        for (int i = 0; i < 64 && !got; i++) begin
            tick("send", acc);
            got = acc;
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL send_timeout: observed not accepted, expected accepted within 64 cycles");
        end
        req_valid = 1'b0;
    endtask

    initial begin
        bit acc;

        // Reset state.
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        #1;
        check_all("post_reset");

        // Single short request, then a 4-cycle hold.
        send(2'd2, 4'd0);
        idle(5);
        send(2'd3, 4'd3);
        idle(8);

        // Three back-to-back requests fill the 2-deep FIFO and stall.
        send(2'd0, 4'd1);
        send(2'd1, 4'd0);
        send(2'd2, 4'd2);
        idle(10);

        // Reset during the second enable cycle of a hold=5 request.
        send(2'd1, 4'd5);
        for (int i = 0; i < S + 2; i++) tick("pre_abort", acc);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort.enable", enable, 1'b0);
        chk("abort.busy",   busy,   1'b0);
        chk("abort.done",   done,   1'b0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        #1;
        check_all("after_abort");
        idle(4);

        // Maximum hold: 16 enable cycles without early wrap.
        send(2'd1, 4'd15);
        idle(22);

        // Randomized traffic with occasional back-to-back pushes.
        for (int i = 0; i < 600; i++) begin
            if (!req_valid && $urandom_range(0, 2) != 0) begin
                req_valid = 1'b1;
                req_addr  = 2'($urandom_range(0, 3));
                req_hold  = ($urandom_range(0, 9) == 0) ? 4'(15) : HOLD_W'($urandom_range(0, 3));
            end
            tick("random", acc);
            if (acc) req_valid = 1'b0;
        end
        idle(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
